// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one shared single-ported memory with a ready handshake.
// Optional round-robin tie-break between the two ports: define MEM_PORT_ARB_RR_EN.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              stall_if_req,
   output logic              stall_mem_req,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              mem_req_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              if_ack_d;
   logic              d_ack_d;
   logic [DATA_W-1:0] if_rdata_d;
   logic [DATA_W-1:0] d_rdata_d;
   logic              if_elig;
   logic              d_elig;
   logic              grant_data;

   // A port whose ack is high this cycle has just been served and must not re-issue yet.
   assign if_elig = if_req & ~if_ack;
   assign d_elig  = d_req & ~d_ack;

   assign stall_if_req  = if_req & ~if_ack;
   assign stall_mem_req = d_req & ~d_ack;

`ifdef MEM_PORT_ARB_RR_EN
   // last_data_q: 1 = data port was granted most recently, 0 = fetch.
   logic last_data_q;
   logic last_data_d;

   assign grant_data = d_elig & (~if_elig | ~last_data_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_data_q <= 1'b0;
      else     last_data_q <= last_data_d;
   end
`else
   assign grant_data = d_elig;
`endif

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state_q   <= state_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         if_ack    <= if_ack_d;
         d_ack     <= d_ack_d;
         if_rdata  <= if_rdata_d;
         d_rdata   <= d_rdata_d;
      end
   end

   // Next state and next register values
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      if_rdata_d  = if_rdata;
      d_rdata_d   = d_rdata;
`ifdef MEM_PORT_ARB_RR_EN
      last_data_d = last_data_q;
`endif

      case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
`ifdef MEM_PORT_ARB_RR_EN
               last_data_d = 1'b1;
`endif
            end else if (if_elig) begin
               state_d     = BUSY_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
`ifdef MEM_PORT_ARB_RR_EN
               last_data_d = 1'b0;
`endif
            end
         end
         BUSY_I: begin
            if (mem_ready) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               // A withdrawn fetch (branch flush) completes silently on the bus.
               if (if_req) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end
         end
         BUSY_D: begin
            if (mem_ready) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               d_ack_d   = 1'b1;
               if (!mem_we) d_rdata_d = mem_rdata;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus, behavioural memory, decoupled monitor.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we, if_ack, d_ack;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic        stall_if_req, stall_mem_req;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int mem_wait = 0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_txn_t;

   mem_txn_t    exp_mem[$];
   logic [31:0] exp_if[$];
   logic [31:0] exp_d[$];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .stall_if_req(stall_if_req), .stall_mem_req(stall_mem_req),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h10) return 32'h0010_0093;
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory: answers after mem_wait wait cycles
   initial begin
      int wcnt;
      wcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (wcnt == mem_wait) begin
               mem_ready = 1'b1;
               mem_rdata = memval(mem_addr);
               wcnt      = 0;
            end else begin
               mem_ready = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT issues or acknowledges
   initial begin
      logic     prev_req;
      logic     d_out;
      mem_txn_t cur;
      mem_txn_t e;
      prev_req = 1'b0;
      d_out    = 1'b0;
      cur      = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            prev_req = 1'b0;
            d_out    = 1'b0;
         end else begin
            if (mem_req && !prev_req) begin
               if (exp_mem.size() == 0) begin
                  check("unexpected_issue", 32'(mem_req), 32'(0));
               end else begin
                  e = exp_mem.pop_front();
                  check("issue_we", 32'(mem_we), 32'(e.we));
                  check("issue_addr", mem_addr, e.addr);
                  check("issue_wdata", mem_wdata, e.wdata);
                  cur = e;
               end
            end else if (mem_req) begin
               check("hold_we", 32'(mem_we), 32'(cur.we));
               check("hold_addr", mem_addr, cur.addr);
               check("hold_wdata", mem_wdata, cur.wdata);
            end
            prev_req = mem_req;

            if (if_ack) begin
               if (exp_if.size() == 0) check("unexpected_if_ack", 32'(if_ack), 32'(0));
               else                    check("if_rdata", if_rdata, exp_if.pop_front());
            end
            if (d_ack) begin
               if (exp_d.size() == 0) check("unexpected_d_ack", 32'(d_ack), 32'(0));
               else                   check("d_rdata", d_rdata, exp_d.pop_front());
            end

            if (d_out && !d_req && !d_ack) check("d_req_withdrawn", 32'(d_req), 32'(1));
            if (d_ack)      d_out = 1'b0;
            else if (d_req) d_out = 1'b1;
         end
      end
   end

   task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdexp, input int waits, input int lat, input string nm);
      int n;
      mem_wait = waits;
      exp_mem.push_back('{we, addr, wdata});
      exp_d.push_back(rdexp);
      @(negedge clk);
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!d_ack && n < 40);
      check({nm, "_ack_cycle"}, 32'(n), 32'(lat));
      @(negedge clk);
      d_req = 1'b0;
   endtask

   task automatic run_i(input logic [31:0] addr, input logic [31:0] rdexp,
                        input int waits, input int lat, input string nm);
      int n;
      mem_wait = waits;
      exp_mem.push_back('{1'b0, addr, 32'h0});
      exp_if.push_back(rdexp);
      @(negedge clk);
      if_addr = addr; if_req = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!if_ack && n < 40);
      check({nm, "_ack_cycle"}, 32'(n), 32'(lat));
      @(negedge clk);
      if_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, ia, da;
      logic saw;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req", 32'(mem_req), 32'(0));
      check("rst_mem_we", 32'(mem_we), 32'(0));
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_if_ack", 32'(if_ack), 32'(0));
      check("rst_d_ack", 32'(d_ack), 32'(0));
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Fetch only, zero wait states
      mem_wait = 0;
      exp_mem.push_back('{1'b0, 32'h10, 32'h0});
      exp_if.push_back(32'h0010_0093);
      @(negedge clk);
      if_addr = 32'h10; if_req = 1'b1;
      #1;
      check("fo_stall_c0", 32'(stall_if_req), 32'(1));
      @(posedge clk); #1;
      check("fo_mem_req_c1", 32'(mem_req), 32'(1));
      check("fo_stall_c1", 32'(stall_if_req), 32'(1));
      @(posedge clk); #1;
      check("fo_if_ack_c2", 32'(if_ack), 32'(1));
      check("fo_stall_c2", 32'(stall_if_req), 32'(0));
      @(negedge clk);
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      run_d(1'b0, 32'h80, 32'h0, 32'hC0DE_0080, 2, 4, "ld");
      run_d(1'b1, 32'h100, 32'hDEAD_BEEF, 32'hC0DE_0080, 3, 5, "st");
      check("st_d_rdata_kept", d_rdata, 32'hC0DE_0080);

      // Contention: fetch 0x20 and load 0x200 raised together
      mem_wait = 0;
`ifdef MEM_PORT_ARB_RR_EN
      exp_mem.push_back('{1'b0, 32'h20, 32'h0});
      exp_mem.push_back('{1'b0, 32'h200, 32'h0});
`else
      exp_mem.push_back('{1'b0, 32'h200, 32'h0});
      exp_mem.push_back('{1'b0, 32'h20, 32'h0});
`endif
      exp_if.push_back(32'hC0DE_0020);
      exp_d.push_back(32'hC0DE_0200);
      @(negedge clk);
      if_addr = 32'h20; if_req = 1'b1;
      d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0; d_req = 1'b1;
      #1;
      check("ct_stall_mem_c0", 32'(stall_mem_req), 32'(1));
      n = 0; ia = 0; da = 0;
      while ((ia == 0 || da == 0) && n < 40) begin
         @(posedge clk); #1; n++;
         if (if_ack && ia == 0) ia = n;
         if (d_ack && da == 0) da = n;
         @(negedge clk);
         if (ia != 0) if_req = 1'b0;
         if (da != 0) d_req = 1'b0;
      end
`ifdef MEM_PORT_ARB_RR_EN
      check("ct_if_ack_cycle", 32'(ia), 32'(2));
      check("ct_d_ack_cycle", 32'(da), 32'(4));
`else
      check("ct_d_ack_cycle", 32'(da), 32'(2));
      check("ct_if_ack_cycle", 32'(ia), 32'(4));
`endif
      repeat (2) @(negedge clk);

      // Fetch withdrawn while the memory is busy
      mem_wait = 2;
      exp_mem.push_back('{1'b0, 32'h40, 32'h0});
      @(negedge clk);
      if_addr = 32'h40; if_req = 1'b1;
      @(posedge clk); #1;
      check("wd_busy", 32'(mem_req), 32'(1));
      @(negedge clk);
      if_req = 1'b0;
      n = 0; saw = 1'b0;
      do begin
         @(posedge clk); #1; n++;
         if (if_ack) saw = 1'b1;
      end while (mem_req && n < 20);
      @(posedge clk); #1;
      if (if_ack) saw = 1'b1;
      check("wd_mem_done", 32'(mem_req), 32'(0));
      check("wd_no_ack", 32'(saw), 32'(0));
      check("wd_rdata_hold", if_rdata, 32'hC0DE_0020);
      run_i(32'h44, 32'hC0DE_0044, 1, 3, "wd_next");

      // Asynchronous reset in the middle of a load
      mem_wait = 5;
      exp_mem.push_back('{1'b0, 32'h300, 32'h0});
      @(negedge clk);
      d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0; d_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rb_busy", 32'(mem_req), 32'(1));
      @(negedge clk);
      rst = 1'b1; d_req = 1'b0;
      #1;
      check("rb_mem_req", 32'(mem_req), 32'(0));
      check("rb_d_ack", 32'(d_ack), 32'(0));
      check("rb_d_rdata", d_rdata, 32'h0);
      check("rb_if_rdata", if_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_d(1'b0, 32'h304, 32'h0, 32'hC0DE_0304, 1, 3, "post_rst");

      repeat (3) @(negedge clk);
      check("left_mem", 32'(exp_mem.size()), 32'(0));
      check("left_if", 32'(exp_if.size()), 32'(0));
      check("left_d", 32'(exp_d.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates between the pipelined core's fetch port and its data port for one shared, single-ported memory with a ready handshake. Each request is registered onto the memory bus, held stable until the memory returns `mem_ready`, and answered with a one-cycle acknowledge. The block also drives the fetch and memory-stage stall requests consumed by the hazard unit. It sits between the core top level and the unified instruction/data memory.

## Interface
- `ADDR_W`, default 32: address width of all ports.
- `DATA_W`, default 32: data width of all ports.

- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_ack` or withdrawn.
- `if_addr`  in  ADDR_W  fetch address (`pc_f`).
- `if_rdata`  out  DATA_W  fetched instruction; valid while `if_ack`=1, held afterwards.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address (`data_addr_m`).
- `d_wdata`  in  DATA_W  store data (`write_data_m`).
- `d_rdata`  out  DATA_W  load data; valid while `d_ack`=1, held afterwards.
- `d_ack`  out  1  one-cycle data completion pulse.
- `stall_if_req`  out  1  equals `if_req & ~if_ack` (combinational).
- `stall_mem_req`  out  1  equals `d_req & ~d_ack` (combinational).
- `mem_req`  out  1  memory transaction valid.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; sampled when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current transaction this cycle.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **IDLE:** the arbiter picks a port if any eligible request is present.
  - A port is ineligible in the cycle its own ack is high.
  - When granted, it registers address, write enable and write data onto `mem_*`, sets `mem_req`=1 and moves to BUSY_I or BUSY_D.
- **Default priority:** data wins over fetch, since the memory-stage instruction is older.
- **BUSY_x:** the `mem_*` outputs are held constant.
  - On `mem_ready`=1: `mem_req` goes to 0, the FSM returns to IDLE, and the ack for the granted port is registered high for the next cycle.
  - For a BUSY_D load, `mem_rdata` is registered into `d_rdata`.
  - For BUSY_I, `mem_rdata` is registered into `if_rdata`.
- Stores leave `d_rdata` unchanged.
- **Fetch withdrawal:** `if_req` may drop during BUSY_I, e.g. on a branch flush.
  - The memory transaction still completes.
  - `if_ack` is suppressed and `if_rdata` is not updated.
- **Data withdrawal:** `d_req` never withdraws mid-transaction. The bench flags it as an error.
- There is no back-to-back issue: IDLE always spends one cycle between transactions.
- A `mem_ready` seen in IDLE is ignored.

## Timing
- **Reset values:** FSM=IDLE; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0; `if_ack`=0, `d_ack`=0; `if_rdata`=0, `d_rdata`=0; last-grant=fetch.
- **Best-case latency:** request seen in IDLE at cycle 0, `mem_req` high in cycle 1, `mem_ready` in cycle 1, ack in cycle 2.
- **General latency:** N wait cycles on `mem_ready` add N cycles.
- **Peak throughput:** one transaction per 2 cycles.
- **Simultaneous `if_req` and `d_req` in IDLE:** data is served first. Fetch is granted in the IDLE cycle that coincides with `d_ack`, so fetch `mem_req` rises 2 cycles after `d_ack`'s predecessor completes.
- **Reset mid-transaction:** outputs return to reset values asynchronously and `mem_req` drops. The memory must discard the partial transaction. No ack is produced.

## Configuration
- **`MEM_PORT_ARB_RR_EN`:**
  - **Defined:** when both ports request in IDLE, the port not granted last wins. The last-grant register updates on every grant.
  - **Undefined:** fixed data-over-fetch priority; the last-grant register is not implemented.
- A single request is always granted immediately in both builds.

## Test plan
- **Fetch only:** `if_req`=1 at `if_addr`=0x0000_0010, `mem_ready` tied 1, `mem_rdata`=0x0010_0093.
  - `mem_req` goes high in cycle 1 with `mem_addr`=0x10.
  - `if_ack` pulses in cycle 2 with `if_rdata`=0x0010_0093.
  - `stall_if_req` is 1 in cycles 0–1.
- **Store with 3 wait states:** `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF.
  - `mem_we`, `mem_addr` and `mem_wdata` are stable for 4 cycles.
  - `d_ack` pulses in cycle 5 and `d_rdata` is unchanged.
- **Contention:** `if_req` and a `d_req` load are raised in the same cycle.
  - Without RR: the data transaction is issued first, then fetch; both acks are single pulses.
  - With `MEM_PORT_ARB_RR_EN` after a prior data grant: fetch is issued first.
- **Fetch withdrawal:** drop `if_req` during BUSY_I, then assert `mem_ready`.
  - FSM returns to IDLE, no `if_ack` pulse, `if_rdata` retains its old value.
- **Reset during BUSY_D:** pulse `rst` for 1 cycle.
  - `mem_req`, `d_ack` and `d_rdata` read 0 immediately, without waiting for a clock edge.
  - A fresh `d_req` afterwards completes normally.
